// File: rtl/mt_seq_pkg.sv
// mt_seq_pkg: shared state encoding, step record and sizing helper for mt_vector_sequencer (MT_SEQ_MASK_EN adds a per-step compare mask)
package mt_seq_pkg;

    localparam int MT_IN_BITS   = 30;
    localparam int MT_OUT_BITS  = 30;
    localparam int MT_HOLD_BITS = 16;

    typedef enum logic [2:0] {
        MT_IDLE,
        MT_APPLY,
        MT_HOLD,
        MT_WAIT,
        MT_FINISH
    } t_mt_seq_state;

    typedef struct packed {
        logic [MT_IN_BITS-1:0]   stim;
        logic [MT_OUT_BITS-1:0]  exp;
        logic [MT_HOLD_BITS-1:0] hold;
`ifdef MT_SEQ_MASK_EN
        logic [MT_OUT_BITS-1:0]  mask;
`endif
    } t_mt_step;

    // ceil(log2(n)); callers keep n >= 2 so every derived width is non-zero
    function automatic int f_log2_size(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/mt_vector_sequencer_if.sv
// mt_vector_sequencer_if: register-side bus (table writes, run control, status); wr_mask_i exists only with MT_SEQ_MASK_EN
interface mt_vector_sequencer_if #(
    parameter int g_in_bits   = mt_seq_pkg::MT_IN_BITS,
    parameter int g_out_bits  = mt_seq_pkg::MT_OUT_BITS,
    parameter int g_max_steps = 16,
    parameter int g_hold_bits = mt_seq_pkg::MT_HOLD_BITS
) ();

    localparam int AW = mt_seq_pkg::f_log2_size(g_max_steps);

    logic                   wr_en_i;
    logic [AW-1:0]          wr_addr_i;
    logic [g_in_bits-1:0]   wr_stim_i;
    logic [g_out_bits-1:0]  wr_exp_i;
    logic [g_hold_bits-1:0] wr_hold_i;
`ifdef MT_SEQ_MASK_EN
    logic [g_out_bits-1:0]  wr_mask_i;
`endif
    logic [AW:0]            num_steps_i;
    logic                   start_i;
    logic                   abort_i;
    logic                   busy_o;
    logic                   done_o;
    logic                   pass_o;
    logic [AW-1:0]          fail_step_o;

    modport master (
        output wr_en_i, wr_addr_i, wr_stim_i, wr_exp_i, wr_hold_i,
`ifdef MT_SEQ_MASK_EN
        wr_mask_i,
`endif
        num_steps_i, start_i, abort_i,
        input  busy_o, done_o, pass_o, fail_step_o
    );

    modport slave (
        input  wr_en_i, wr_addr_i, wr_stim_i, wr_exp_i, wr_hold_i,
`ifdef MT_SEQ_MASK_EN
        wr_mask_i,
`endif
        num_steps_i, start_i, abort_i,
        output busy_o, done_o, pass_o, fail_step_o
    );

endinterface

// File: rtl/mt_seq_step_ram.sv
// mt_seq_step_ram: step table, synchronous write and asynchronous read; contents are never reset
module mt_seq_step_ram
    import mt_seq_pkg::*;
#(
    parameter int g_max_steps = 16,
    parameter int g_addr_bits = f_log2_size(g_max_steps)
) (
    input  logic                   clk_i,
    input  logic                   we_i,
    input  logic [g_addr_bits-1:0] waddr_i,
    input  t_mt_step               wdata_i,
    input  logic [g_addr_bits-1:0] raddr_i,
    output t_mt_step               rdata_o
);

    t_mt_step mem_q [g_max_steps];

    // table write port; no reset so the program survives a mid-run reset
    always_ff @(posedge clk_i)
        if (we_i) mem_q[waddr_i] <= wdata_i;

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mt_vector_sequencer.sv
// mt_vector_sequencer: plays a programmed table of stimulus/hold/expected steps into a test top and reports pass/fail (MT_SEQ_MASK_EN adds masked compare)
module mt_vector_sequencer
    import mt_seq_pkg::*;
#(
    parameter int g_in_bits   = MT_IN_BITS,
    parameter int g_out_bits  = MT_OUT_BITS,
    parameter int g_max_steps = 16,
    parameter int g_hold_bits = MT_HOLD_BITS,
    parameter int g_timeout   = 1024
) (
    input  logic                  clk_sys_i,
    input  logic                  rst_n_i,
    mt_vector_sequencer_if.slave  bus_if,
    output logic [g_in_bits-1:0]  input_vector_o,
    input  logic [g_out_bits-1:0] output_vector_i
);

    localparam int AW = f_log2_size(g_max_steps);
    localparam int TW = f_log2_size(g_timeout);
    localparam logic [AW:0]   MAX_STEPS = (AW+1)'(g_max_steps);
    localparam logic [TW-1:0] TMO_LAST  = TW'(g_timeout - 1);

    localparam logic [2:0] S_IDLE   = MT_IDLE;
    localparam logic [2:0] S_APPLY  = MT_APPLY;
    localparam logic [2:0] S_HOLD   = MT_HOLD;
    localparam logic [2:0] S_WAIT   = MT_WAIT;
    localparam logic [2:0] S_FINISH = MT_FINISH;

    logic [2:0]             state_q, state_d;
    logic [AW-1:0]          step_q, step_d;
    logic [AW-1:0]          fail_step_q, fail_step_d;
    logic [AW:0]            count_q, count_d;
    logic [g_hold_bits-1:0] hold_q, hold_d;
    logic [TW-1:0]          tmo_q, tmo_d;
    logic [g_in_bits-1:0]   vec_q, vec_d;
    logic [g_out_bits-1:0]  resp_q;
    logic                   pass_q, pass_d;
    logic [AW:0]            num_sat;
    logic                   busy, match, last, timeout;
    t_mt_step               wr_step, rd_step;

    // pack the bus write fields into one table record
    always_comb begin
        wr_step      = '0;
        wr_step.stim = bus_if.wr_stim_i;
        wr_step.exp  = bus_if.wr_exp_i;
        wr_step.hold = bus_if.wr_hold_i;
`ifdef MT_SEQ_MASK_EN
        wr_step.mask = bus_if.wr_mask_i;
`endif
    end

    mt_seq_step_ram #(
        .g_max_steps (g_max_steps),
        .g_addr_bits (AW)
    ) u_ram (
        .clk_i   (clk_sys_i),
        .we_i    (bus_if.wr_en_i & ~busy),
        .waddr_i (bus_if.wr_addr_i),
        .wdata_i (wr_step),
        .raddr_i (step_q),
        .rdata_o (rd_step)
    );

    assign busy    = (state_q == S_APPLY) || (state_q == S_HOLD) || (state_q == S_WAIT);
    assign num_sat = (bus_if.num_steps_i > MAX_STEPS) ? MAX_STEPS : bus_if.num_steps_i;
    assign last    = {1'b0, step_q} == (count_q - (AW+1)'(1));
    assign timeout = tmo_q == TMO_LAST;
`ifdef MT_SEQ_MASK_EN
    assign match   = (resp_q & rd_step.mask) == (rd_step.exp & rd_step.mask);
`else
    assign match   = resp_q == rd_step.exp;
`endif

    // sequencer next state: abort beats match, match beats timeout
    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        fail_step_d = fail_step_q;
        count_d     = count_q;
        hold_d      = hold_q;
        tmo_d       = tmo_q;
        vec_d       = vec_q;
        pass_d      = pass_q;
        if (state_q == S_IDLE) begin
            if (bus_if.start_i) begin
                count_d = num_sat;
                step_d  = '0;
                pass_d  = num_sat == '0;
                state_d = (num_sat == '0) ? S_FINISH : S_APPLY;
            end
        end else if (state_q == S_FINISH) begin
            state_d = S_IDLE;
        end else if (bus_if.abort_i) begin
            fail_step_d = step_q;
            pass_d      = 1'b0;
            state_d     = S_FINISH;
        end else if (state_q == S_APPLY) begin
            vec_d   = rd_step.stim;
            hold_d  = rd_step.hold;
            state_d = S_HOLD;
        end else if (state_q == S_HOLD) begin
            hold_d  = (hold_q == '0) ? '0 : hold_q - g_hold_bits'(1);
            tmo_d   = '0;
            state_d = (hold_d == '0) ? S_WAIT : S_HOLD;
        end else if (state_q == S_WAIT) begin
            if (match) begin
                step_d  = last ? step_q : step_q + AW'(1);
                pass_d  = last;
                state_d = last ? S_FINISH : S_APPLY;
            end else if (timeout) begin
                fail_step_d = step_q;
                pass_d      = 1'b0;
                state_d     = S_FINISH;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end else begin
            state_d = S_IDLE;
        end
    end

    // state, counters, outputs and the one-cycle response register
    always_ff @(posedge clk_sys_i or negedge rst_n_i)
        if (!rst_n_i) begin
            state_q     <= S_IDLE;
            step_q      <= '0;
            fail_step_q <= '0;
            count_q     <= '0;
            hold_q      <= '0;
            tmo_q       <= '0;
            vec_q       <= '0;
            resp_q      <= '0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            fail_step_q <= fail_step_d;
            count_q     <= count_d;
            hold_q      <= hold_d;
            tmo_q       <= tmo_d;
            vec_q       <= vec_d;
            resp_q      <= output_vector_i;
            pass_q      <= pass_d;
        end

    assign input_vector_o     = vec_q;
    assign bus_if.busy_o      = busy;
    assign bus_if.done_o      = state_q == S_FINISH;
    assign bus_if.pass_o      = pass_q;
    assign bus_if.fail_step_o = fail_step_q;

endmodule
